w0rm_core_memory_queued: RTL

W0RM_CORE_MEMORY_QUEUED -- requirements
Module: W0RM_Core_Memory_Queued

---
 rtl/w0rm_core_memory_queued.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/w0rm_core_memory_queued.sv
// Queued memory front-end: buffers requests in a small FIFO and runs them one
// at a time over a simple valid-strobed data bus, with a per-request wait timeout.
module w0rm_core_memory_queued #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int USER_WIDTH     = 1,
  parameter int QUEUE_DEPTH    = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mem_valid_i,
  input  logic                  mem_write,
  input  logic                  mem_read,
  input  logic                  mem_is_pop,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_data,
  input  logic [USER_WIDTH-1:0] user_data_in,
  output logic                  mem_ready,
  output logic                  mem_output_valid,
  output logic [DATA_WIDTH-1:0] mem_data_out,
  output logic [ADDR_WIDTH-1:0] mem_sp_out,
  output logic                  mem_error,
  output logic [USER_WIDTH-1:0] user_data_out,
  output logic                  data_bus_valid_out,
  output logic                  data_bus_write_out,
  output logic                  data_bus_read_out,
  output logic [ADDR_WIDTH-1:0] data_bus_addr_out,
  output logic [DATA_WIDTH-1:0] data_bus_data_out,
  input  logic                  data_bus_valid_in,
  input  logic [DATA_WIDTH-1:0] data_bus_data_in
);

  localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(QUEUE_DEPTH);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

  typedef struct packed {
    logic                  wr;
    logic                  rd;
    logic                  pop;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic [USER_WIDTH-1:0] user;
  } req_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  req_t                  q_mem [QUEUE_DEPTH];
  req_t                  head;
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      count;
  state_t                state, state_nx;
  logic [TO_W-1:0]       to_cnt;
  logic                  enq, deq, issue, done_rsp, done_to, done_nop;
  logic                  cur_pop;
  logic [USER_WIDTH-1:0] cur_user;

  // A pop read moves the stack pointer up by one data word, wrapping at ADDR_WIDTH.
  function automatic logic [ADDR_WIDTH-1:0] next_sp(input logic [ADDR_WIDTH-1:0] addr,
                                                     input logic rd, input logic pop);
    next_sp = (rd && pop) ? addr + ADDR_WIDTH'(DATA_WIDTH / 8) : addr;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] read_result(input logic rd,
                                                        input logic [DATA_WIDTH-1:0] data);
    read_result = rd ? data : '0;
  endfunction

  assign mem_ready = (count != FULL_CNT);
  assign enq       = mem_valid_i && mem_ready;
  assign head      = q_mem[rd_ptr];

  // Queue storage and occupancy
  always_ff @(posedge clk) begin
    if (enq) begin
      q_mem[wr_ptr] <= '{wr: mem_write, rd: mem_read, pop: mem_is_pop,
                         addr: mem_addr, data: mem_data, user: user_data_in};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + PTR_W'(1);
      if (deq) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(enq) - CNT_W'(deq);
    end
  end

  // Transaction FSM
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    deq      = 1'b0;
    issue    = 1'b0;
    done_rsp = 1'b0;
    done_to  = 1'b0;
    done_nop = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) begin
          deq = 1'b1;
          if (head.wr || head.rd) begin
            issue    = 1'b1;
            state_nx = ISSUE;
          end else begin
            done_nop = 1'b1;
          end
        end
      end
      ISSUE: state_nx = WAIT;
      WAIT: begin
        // A response on the expiry edge still counts as a normal completion.
        if (data_bus_valid_in) begin
          done_rsp = 1'b1;
          state_nx = IDLE;
        end else if (to_cnt == TO_LAST) begin
          done_to  = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || state != WAIT) to_cnt <= '0;
    else                        to_cnt <= to_cnt + TO_W'(1);
  end

  // Bus request and completion registers
  always_ff @(posedge clk) begin
    if (issue) begin
      cur_pop  <= head.pop;
      cur_user <= head.user;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_output_valid   <= 1'b0;
      mem_data_out       <= '0;
      mem_sp_out         <= '0;
      mem_error          <= 1'b0;
      user_data_out      <= '0;
      data_bus_valid_out <= 1'b0;
      data_bus_write_out <= 1'b0;
      data_bus_read_out  <= 1'b0;
      data_bus_addr_out  <= '0;
      data_bus_data_out  <= '0;
    end else begin
      mem_output_valid   <= 1'b0;
      data_bus_valid_out <= issue;
      if (issue) begin
        data_bus_write_out <= head.wr;
        data_bus_read_out  <= head.rd;
        data_bus_addr_out  <= head.addr;
        data_bus_data_out  <= head.data;
      end
      if (done_nop) begin
        mem_output_valid <= 1'b1;
        mem_data_out     <= '0;
        mem_error        <= 1'b0;
        mem_sp_out       <= head.addr;
        user_data_out    <= head.user;
      end
      if (done_rsp || done_to) begin
        mem_output_valid <= 1'b1;
        mem_error        <= done_to;
        mem_data_out     <= done_rsp ? read_result(data_bus_read_out, data_bus_data_in) : '0;
        mem_sp_out       <= next_sp(data_bus_addr_out, data_bus_read_out, cur_pop);
        user_data_out    <= cur_user;
      end
    end
  end

endmodule
